// File: rtl/rob_reorder_stage.sv
// ---------------------------------------------------------------------------
// rob_reorder_stage
//
// Tag-ordered reorder stage. Tags are handed out in strict circular order on
// the allocation side; returning R beats are parked in the slot named by their
// tag. Beats then leave through a registered output strictly in allocation
// order. Responses may come back in any order, and they are still delivered in
// request order.
//
// Optional feature macro: ROB_TAG_CHECK_EN
//   defined   - beats for unallocated tags, or for slots that are already
//               filled, are accepted but dropped. err_cnt counts them and
//               saturates at 255.
//   undefined - no check is made. Such a beat overwrites its slot and sets the
//               slot's filled bit. err_cnt is tied to zero.
//
// Ports
//   clk, rst_n        clock; asynchronous active-low reset
//   alloc_req         request path asks for a tag this cycle
//   alloc_ready       a free tag exists (occupancy < NSLOT)
//   alloc_tag         tag granted on alloc_req && alloc_ready
//   in_id/in_data/in_resp/in_last/in_tagid/in_valid/in_ready
//                     beats from the incoming response buffer
//   out_id/out_data/out_resp/out_last/out_tagid/out_valid/out_ready
//                     in-order beats to the requesting master (registered)
//   occupancy         allocated-but-not-released tag count
//   err_cnt           illegal-beat counter (ROB_TAG_CHECK_EN only)
// ---------------------------------------------------------------------------
module rob_reorder_stage #(
    parameter int ID_WIDTH   = 4,
    parameter int DATA_WIDTH = 64,
    parameter int RESP_WIDTH = 2,
    parameter int TAG_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  alloc_req,
    output logic                  alloc_ready,
    output logic [TAG_WIDTH-1:0]  alloc_tag,

    input  logic [ID_WIDTH-1:0]   in_id,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [RESP_WIDTH-1:0] in_resp,
    input  logic                  in_last,
    input  logic [TAG_WIDTH-1:0]  in_tagid,
    input  logic                  in_valid,
    output logic                  in_ready,

    output logic [ID_WIDTH-1:0]   out_id,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RESP_WIDTH-1:0] out_resp,
    output logic                  out_last,
    output logic [TAG_WIDTH-1:0]  out_tagid,
    output logic                  out_valid,
    input  logic                  out_ready,

    output logic [TAG_WIDTH:0]    occupancy,
    output logic [7:0]            err_cnt
);

    localparam int NSLOT = 1 << TAG_WIDTH;
    localparam logic [TAG_WIDTH:0] PTR_ONE = (TAG_WIDTH + 1)'(1);

    // Pointers carry one extra wrap bit, so full and empty stay distinguishable.
    logic [TAG_WIDTH:0]    head;
    logic [TAG_WIDTH:0]    tail;
    logic [TAG_WIDTH-1:0]  head_idx;
    logic [NSLOT-1:0]      filled;

    logic [ID_WIDTH-1:0]   slot_id   [NSLOT];
    logic [DATA_WIDTH-1:0] slot_data [NSLOT];
    logic [RESP_WIDTH-1:0] slot_resp [NSLOT];
    logic                  slot_last [NSLOT];

    logic full;
    logic alloc_fire;
    logic release_fire;
    logic write_ok;

    // Occupancy never exceeds NSLOT, so its MSB is set only when full.
    assign occupancy   = tail - head;
    assign full        = occupancy[TAG_WIDTH];
    assign alloc_ready = ~full;
    assign alloc_tag   = tail[TAG_WIDTH-1:0];
    assign head_idx    = head[TAG_WIDTH-1:0];

    // Slots are reserved at allocation time, so the input never back-pressures.
    assign in_ready    = rst_n;

    assign alloc_fire  = alloc_req & alloc_ready;

    // filled is sampled before the edge. A beat that lands in the head slot
    // this cycle is therefore released on the following cycle.
    assign release_fire = filled[head_idx] & (~out_valid | out_ready);

`ifdef ROB_TAG_CHECK_EN
    logic [TAG_WIDTH-1:0] tag_offset;
    logic                 tag_live;
    logic                 write_bad;

    // A tag is live when its circular distance from head is below occupancy.
    assign tag_offset = in_tagid - head_idx;
    assign tag_live   = ({1'b0, tag_offset} < occupancy);
    assign write_ok   = in_valid & tag_live & ~filled[in_tagid];
    assign write_bad  = in_valid & ~write_ok;

    // Dropped beats are counted. The counter saturates instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= 8'd0;
        end else if (write_bad && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`else
    assign write_ok = in_valid;
    assign err_cnt  = 8'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (alloc_fire) begin
                tail <= tail + PTR_ONE;
            end
            if (release_fire) begin
                head <= head + PTR_ONE;
            end
        end
    end

    // The set comes after the clear, so a write to the slot being released
    // leaves that slot marked filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filled <= '0;
        end else begin
            if (release_fire) begin
                filled[head_idx] <= 1'b0;
            end
            if (write_ok) begin
                filled[in_tagid] <= 1'b1;
            end
        end
    end

    // Payload storage needs no reset. The filled bits decide what is valid.
    always_ff @(posedge clk) begin
        if (write_ok) begin
            slot_id[in_tagid]   <= in_id;
            slot_data[in_tagid] <= in_data;
            slot_resp[in_tagid] <= in_resp;
            slot_last[in_tagid] <= in_last;
        end
    end

    // Registered output stage. The payload is held while out_valid waits for
    // out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
            out_resp  <= '0;
            out_last  <= 1'b0;
            out_tagid <= '0;
        end else if (release_fire) begin
            out_valid <= 1'b1;
            out_id    <= slot_id[head_idx];
            out_data  <= slot_data[head_idx];
            out_resp  <= slot_resp[head_idx];
            out_last  <= slot_last[head_idx];
            out_tagid <= head_idx;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rob_reorder_stage.sv
// ---------------------------------------------------------------------------
// tb_rob_reorder_stage
//
// Bench for rob_reorder_stage. It covers:
//   - a vector table for the out-of-order return example;
//   - hand-written sequences for full/wrap, output hold and mid-run reset;
//   - the tag check, when the design is built with ROB_TAG_CHECK_EN;
//   - randomized traffic against a sequence-number reference model.
// ---------------------------------------------------------------------------
module tb_rob_reorder_stage;

    logic        clk;
    logic        rst_n;
    logic        alloc_req;
    logic        alloc_ready;
    logic [3:0]  alloc_tag;
    logic [3:0]  in_id;
    logic [63:0] in_data;
    logic [1:0]  in_resp;
    logic        in_last;
    logic [3:0]  in_tagid;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  out_id;
    logic [63:0] out_data;
    logic [1:0]  out_resp;
    logic        out_last;
    logic [3:0]  out_tagid;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  occupancy;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    rob_reorder_stage #(
        .ID_WIDTH(4), .DATA_WIDTH(64), .RESP_WIDTH(2), .TAG_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .in_id(in_id), .in_data(in_data), .in_resp(in_resp), .in_last(in_last),
        .in_tagid(in_tagid), .in_valid(in_valid), .in_ready(in_ready),
        .out_id(out_id), .out_data(out_data), .out_resp(out_resp), .out_last(out_last),
        .out_tagid(out_tagid), .out_valid(out_valid), .out_ready(out_ready),
        .occupancy(occupancy), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alloc_req;
        logic        in_valid;
        logic [3:0]  in_tagid;
        logic [63:0] in_data;
        logic        out_ready;
        logic        exp_ready;
        logic [3:0]  exp_tag;
        logic [4:0]  exp_occ;
        logic        exp_ov;
        logic [3:0]  exp_otag;
        logic [63:0] exp_odata;
    } vec_t;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it, and settle 1ns past the edge.
    task automatic applyStimulus(input logic ar, input logic iv, input logic [3:0] itag,
                                 input logic [63:0] idata, input logic [3:0] iid,
                                 input logic [1:0] iresp, input logic ilast,
                                 input logic ordy);
        alloc_req = ar;
        in_valid  = iv;
        in_tagid  = itag;
        in_data   = idata;
        in_id     = iid;
        in_resp   = iresp;
        in_last   = ilast;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ordy);
        applyStimulus(1'b0, 1'b0, 4'd0, 64'd0, 4'd0, 2'd0, 1'b0, ordy);
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst_n     = 1'b0;
        alloc_req = 1'b0;
        in_valid  = 1'b0;
        in_tagid  = '0;
        in_data   = '0;
        in_id     = '0;
        in_resp   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model. Each allocation gets an unbounded sequence number;
    // returned beats are keyed by that number, and the output delivers them
    // in ascending sequence order.
    int    m_head;
    int    m_tail;
    beat_t m_ret[int];
    bit    m_ov;
    beat_t m_out;
    int    m_out_tag;

    task automatic randomTraffic(input int ncycles);
        for (int c = 0; c < ncycles; c++) begin
            int    cands[$];
            logic  ar;
            logic  iv;
            logic  ordy;
            int    wseq;
            beat_t b;
            bit    grant;
            bit    rel;

            ar   = ($urandom_range(0, 2) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            for (int s = m_head; s < m_tail; s++) begin
                if (!m_ret.exists(s)) cands.push_back(s);
            end
            iv   = (cands.size() > 0) && ($urandom_range(0, 2) != 0);
            wseq = 0;
            b.id   = 4'($urandom);
            b.data = {$urandom, $urandom};
            b.resp = 2'($urandom);
            b.last = 1'($urandom);
            if (iv) wseq = cands[$urandom_range(0, cands.size() - 1)];

            // Grant and release are decided from the state before this edge.
            grant = ar && ((m_tail - m_head) < 16);
            rel   = m_ret.exists(m_head) && (!m_ov || ordy);
            if (iv) m_ret[wseq] = b;
            if (grant) m_tail++;
            if (rel) begin
                m_out     = m_ret[m_head];
                m_out_tag = m_head % 16;
                m_ret.delete(m_head);
                m_head++;
                m_ov = 1'b1;
            end else if (m_ov && ordy) begin
                m_ov = 1'b0;
            end

            applyStimulus(ar, iv, 4'(wseq % 16), b.data, b.id, b.resp, b.last, ordy);

            checkOutput("rnd_occupancy", 64'(occupancy), 64'(m_tail - m_head));
            checkOutput("rnd_alloc_ready", 64'(alloc_ready), 64'((m_tail - m_head) < 16));
            checkOutput("rnd_alloc_tag", 64'(alloc_tag), 64'(m_tail % 16));
            checkOutput("rnd_out_valid", 64'(out_valid), 64'(m_ov));
            checkOutput("rnd_err_cnt", 64'(err_cnt), 64'd0);
            if (m_ov) begin
                checkOutput("rnd_out_tagid", 64'(out_tagid), 64'(m_out_tag));
                checkOutput("rnd_out_data", out_data, m_out.data);
                checkOutput("rnd_out_id", 64'(out_id), 64'(m_out.id));
                checkOutput("rnd_out_resp", 64'(out_resp), 64'(m_out.resp));
                checkOutput("rnd_out_last", 64'(out_last), 64'(m_out.last));
            end
        end
    endtask

    initial begin
        // Out-of-order return example, one table row per cycle.
        vecs[0]  = '{1'b1, 1'b0, 4'd0, 64'h00, 1'b1, 1'b1, 4'd1, 5'd1, 1'b0, 4'd0, 64'h00};
        vecs[1]  = '{1'b1, 1'b0, 4'd0, 64'h00, 1'b1, 1'b1, 4'd2, 5'd2, 1'b0, 4'd0, 64'h00};
        vecs[2]  = '{1'b1, 1'b0, 4'd0, 64'h00, 1'b1, 1'b1, 4'd3, 5'd3, 1'b0, 4'd0, 64'h00};
        vecs[3]  = '{1'b1, 1'b0, 4'd0, 64'h00, 1'b1, 1'b1, 4'd4, 5'd4, 1'b0, 4'd0, 64'h00};
        vecs[4]  = '{1'b0, 1'b1, 4'd3, 64'h33, 1'b1, 1'b1, 4'd4, 5'd4, 1'b0, 4'd0, 64'h00};
        vecs[5]  = '{1'b0, 1'b1, 4'd1, 64'h11, 1'b1, 1'b1, 4'd4, 5'd4, 1'b0, 4'd0, 64'h00};
        vecs[6]  = '{1'b0, 1'b1, 4'd0, 64'h00, 1'b1, 1'b1, 4'd4, 5'd4, 1'b0, 4'd0, 64'h00};
        vecs[7]  = '{1'b0, 1'b0, 4'd0, 64'h00, 1'b1, 1'b1, 4'd4, 5'd3, 1'b1, 4'd0, 64'h00};
        vecs[8]  = '{1'b0, 1'b0, 4'd0, 64'h00, 1'b1, 1'b1, 4'd4, 5'd2, 1'b1, 4'd1, 64'h11};
        vecs[9]  = '{1'b0, 1'b1, 4'd2, 64'h22, 1'b1, 1'b1, 4'd4, 5'd2, 1'b0, 4'd0, 64'h00};
        vecs[10] = '{1'b0, 1'b0, 4'd0, 64'h00, 1'b1, 1'b1, 4'd4, 5'd1, 1'b1, 4'd2, 64'h22};
        vecs[11] = '{1'b0, 1'b0, 4'd0, 64'h00, 1'b1, 1'b1, 4'd4, 5'd0, 1'b1, 4'd3, 64'h33};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 64'h00, 1'b1, 1'b1, 4'd4, 5'd0, 1'b0, 4'd0, 64'h00};

        rst_n = 1'b0;
        alloc_req = 1'b0; in_valid = 1'b0; in_tagid = '0; in_data = '0;
        in_id = '0; in_resp = '0; in_last = 1'b0; out_ready = 1'b0;
        #12;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_alloc_ready", 64'(alloc_ready), 64'd1);
        checkOutput("rst_alloc_tag", 64'(alloc_tag), 64'd0);
        checkOutput("rst_err_cnt", 64'(err_cnt), 64'd0);
        applyReset();
        checkOutput("post_rst_in_ready", 64'(in_ready), 64'd1);

        // Table-driven out-of-order return.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].alloc_req, vecs[i].in_valid, vecs[i].in_tagid,
                          vecs[i].in_data, vecs[i].in_tagid, 2'd0, 1'b1, vecs[i].out_ready);
            checkOutput($sformatf("vec%0d_alloc_ready", i), 64'(alloc_ready), 64'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_alloc_tag", i), 64'(alloc_tag), 64'(vecs[i].exp_tag));
            checkOutput($sformatf("vec%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].exp_occ));
            checkOutput($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                checkOutput($sformatf("vec%0d_out_tagid", i), 64'(out_tagid), 64'(vecs[i].exp_otag));
                checkOutput($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_odata);
            end
        end

        // Fill all 16 slots, check that a further request is ignored, then
        // release one slot and check the tail wrap.
        applyReset();
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 4'd0, 2'd0, 1'b0, 1'b1);
        end
        checkOutput("full_alloc_ready", 64'(alloc_ready), 64'd0);
        checkOutput("full_occupancy", 64'(occupancy), 64'd16);
        applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 4'd0, 2'd0, 1'b0, 1'b1);
        checkOutput("full_ignored_occ", 64'(occupancy), 64'd16);
        checkOutput("full_ignored_tag", 64'(alloc_tag), 64'd0);
        applyStimulus(1'b0, 1'b1, 4'd0, 64'hA0, 4'd0, 2'd0, 1'b1, 1'b1);
        checkOutput("full_write_occ", 64'(occupancy), 64'd16);
        idle(1'b1);
        checkOutput("full_rel_occ", 64'(occupancy), 64'd15);
        checkOutput("full_rel_ready", 64'(alloc_ready), 64'd1);
        checkOutput("full_rel_tag", 64'(alloc_tag), 64'd0);
        checkOutput("full_rel_out_data", out_data, 64'hA0);
        applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 4'd0, 2'd0, 1'b0, 1'b1);
        checkOutput("wrap_alloc_tag", 64'(alloc_tag), 64'd1);
        checkOutput("wrap_occupancy", 64'(occupancy), 64'd16);
        checkOutput("wrap_out_valid", 64'(out_valid), 64'd0);

        // Hold the output while out_ready is low.
        applyReset();
        applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd0, 64'hBEEF, 4'd5, 2'd2, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd1, 64'hCAFE, 4'd6, 2'd1, 1'b0, 1'b0);
        checkOutput("hold_first_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            checkOutput($sformatf("hold%0d_valid", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("hold%0d_data", i), out_data, 64'hBEEF);
            checkOutput($sformatf("hold%0d_tagid", i), 64'(out_tagid), 64'd0);
            checkOutput($sformatf("hold%0d_occ", i), 64'(occupancy), 64'd1);
        end
        idle(1'b1);
        checkOutput("hold_next_valid", 64'(out_valid), 64'd1);
        checkOutput("hold_next_tagid", 64'(out_tagid), 64'd1);
        checkOutput("hold_next_data", out_data, 64'hCAFE);
        checkOutput("hold_next_id", 64'(out_id), 64'd6);
        checkOutput("hold_next_resp", 64'(out_resp), 64'd1);
        checkOutput("hold_next_occ", 64'(occupancy), 64'd0);
        idle(1'b1);
        checkOutput("hold_drain_valid", 64'(out_valid), 64'd0);

        // Reset in mid-operation with 8 tags outstanding and out_valid high.
        applyReset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 4'd0, 2'd0, 1'b0, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 4'd0, 64'h77, 4'd0, 2'd0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'd1, 64'h78, 4'd0, 2'd0, 1'b1, 1'b0);
        checkOutput("mid_pre_valid", 64'(out_valid), 64'd1);
        checkOutput("mid_pre_occ", 64'(occupancy), 64'd7);
        rst_n = 1'b0;
        #2;
        checkOutput("mid_rst_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_occ", 64'(occupancy), 64'd0);
        checkOutput("mid_rst_tag", 64'(alloc_tag), 64'd0);
        checkOutput("mid_rst_data", out_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle(1'b1);
            checkOutput($sformatf("mid_after%0d_valid", i), 64'(out_valid), 64'd0);
        end

`ifdef ROB_TAG_CHECK_EN
        // Illegal and duplicate beats are dropped and counted.
        applyReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 64'd0, 4'd0, 2'd0, 1'b0, 1'b1);
        end
        applyStimulus(1'b0, 1'b1, 4'd5, 64'h55, 4'd0, 2'd0, 1'b1, 1'b1);
        checkOutput("chk_unalloc_err", 64'(err_cnt), 64'd1);
        idle(1'b1);
        checkOutput("chk_unalloc_noout", 64'(out_valid), 64'd0);
        applyStimulus(1'b0, 1'b1, 4'd1, 64'h11, 4'd0, 2'd0, 1'b1, 1'b1);
        checkOutput("chk_legal_err", 64'(err_cnt), 64'd1);
        applyStimulus(1'b0, 1'b1, 4'd1, 64'h99, 4'd0, 2'd0, 1'b1, 1'b1);
        checkOutput("chk_dup_err", 64'(err_cnt), 64'd2);
        applyStimulus(1'b0, 1'b1, 4'd0, 64'h00, 4'd0, 2'd0, 1'b1, 1'b1);
        idle(1'b1);
        checkOutput("chk_rel0_valid", 64'(out_valid), 64'd1);
        checkOutput("chk_rel0_tag", 64'(out_tagid), 64'd0);
        idle(1'b1);
        checkOutput("chk_rel1_tag", 64'(out_tagid), 64'd1);
        checkOutput("chk_rel1_data", out_data, 64'h11);
        idle(1'b1);
        checkOutput("chk_stall_valid", 64'(out_valid), 64'd0);
        checkOutput("chk_stall_occ", 64'(occupancy), 64'd1);
`endif

        // Randomized traffic against the reference model.
        applyReset();
        m_head = 0;
        m_tail = 0;
        m_ret.delete();
        m_ov = 1'b0;
        m_out_tag = 0;
        m_out = '{4'd0, 64'd0, 2'd0, 1'b0};
        randomTraffic(600);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rob_reorder_stage.md
# rob_reorder_stage

Tag-ordered reorder stage that sits directly downstream of the incoming response buffer and upstream of the requesting master. It allocates tags in strict circular order to the request path, stores each returned R-channel beat in the slot indexed by its tag, and releases beats on a registered output strictly in allocation order. It is the core of the ROB: responses arrive in any order and leave in request order.

## Interface
- ID_WIDTH, 4: AXI ID width carried through unchanged
- DATA_WIDTH, 64: R data width
- RESP_WIDTH, 2: R resp width
- TAG_WIDTH, 4: tag width; slot count NSLOT = 2^TAG_WIDTH
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc_req  in  1  request path asks for a tag this cycle
- alloc_ready  out  1  a free tag is available (count < NSLOT)
- alloc_tag  out  TAG_WIDTH  tag granted when alloc_req && alloc_ready (equals tail pointer low bits)
- in_if  r_if.slave  bundle  beats from the incoming response buffer (id, data, resp, last, tagid, valid, ready)
- out_if  r_if.master  bundle  in-order beats to the requesting master
- occupancy  out  TAG_WIDTH+1  allocated-but-not-released tag count
- err_cnt  out  8  illegal-beat counter (only meaningful with ROB_TAG_CHECK_EN)

## Operation
- State: head, tail pointers, TAG_WIDTH+1 bits each (MSB is wrap bit); per-slot filled bit; per-slot payload {id, data, resp, last}; output register.
- occupancy = tail - head (modulo 2^(TAG_WIDTH+1)); full when occupancy == NSLOT, empty when 0.
- Allocation: alloc_ready = !full; on alloc_req && alloc_ready, tail increments; alloc_tag = tail[TAG_WIDTH-1:0].
- Write: in_if.ready = 1 whenever rst_n high (slots are pre-reserved). On in_if.valid, payload stored in slot tagid, filled[tagid] set.
- Release: when filled[head] && (!out_if.valid || out_if.ready): output register loaded from slot head, out_if.valid set, filled[head] cleared, head increments.
- Otherwise, out_if.ready && out_if.valid clears out_if.valid.
- out_if.tagid carries the released tag; id/data/resp/last passed through unchanged.
- Simultaneous alloc and release: both pointers move; occupancy unchanged.
- Beat written to slot head in the same cycle head is eligible: not released that cycle (filled read pre-edge); released next cycle.
- Alloc while full: ignored, tail unchanged. Release while head slot unfilled: stall, no bubble fill from later slots.

## Timing
- Reset (rst_n low, async): head=0, tail=0, all filled=0, out_if.valid=0, out_if payload=0, alloc_ready=1 after reset, occupancy=0, err_cnt=0, in_if.ready=0 during reset.
- Write-to-output latency: beat accepted at edge N into head slot -> out_if.valid high after edge N+1.
- Back-to-back release: one beat per cycle while out_if.ready=1 and consecutive slots filled.
- alloc_tag/alloc_ready combinational from pointers; no same-cycle dependence on alloc_req.
- Reset mid-operation discards all slots and the output register; no beat emitted after reset release until new allocation and write.

## Configuration
- ROB_TAG_CHECK_EN defined: a beat whose tagid is not allocated (outside [head, tail)) or whose slot is already filled is accepted (ready=1) but dropped; err_cnt increments, saturating at 255.
- Undefined: no check; such a beat overwrites the slot and sets filled; err_cnt tied to 0.

## Test plan
- Allocate tags 0,1,2,3; return beats tags 3,1,0,2 with data 0x33,0x11,0x00,0x22, out_if.ready=1 -> output data order 0x00,0x11,0x22,0x33, tagid 0,1,2,3.
- Allocate 16 tags (TAG_WIDTH=4) -> alloc_ready=0, occupancy=16; 17th alloc_req ignored; release one -> alloc_ready=1, next alloc_tag=0 (wrap).
- Head beat filled, out_if.ready held low 5 cycles -> out_if.valid stays 1, payload stable, head unchanged; ready high -> next slot released following cycle.
- Assert rst_n low with 8 tags outstanding and out_if.valid=1 -> out_if.valid=0, occupancy=0, alloc_tag=0 immediately.
- With ROB_TAG_CHECK_EN: beat tagid 5 while only tags 0-2 allocated -> dropped, err_cnt=1, no output; duplicate beat on filled tag 1 -> err_cnt=2, original data 0x11 released.
